// File: rtl/pending_prio_encoder.sv
// pending_prio_encoder: accumulates N request lines into a pending register and
// hands out one encoded index per valid/ready handshake.
// Default build: the highest pending index is always offered first.
// Define PENDING_PRIO_ENCODER_RR_EN to get round-robin selection with a rotating pointer.
module pending_prio_encoder #(
  parameter  int N     = 8,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o,
  output logic [N-1:0]     pending_o,
  output logic             overflow_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

  localparam logic [N-1:0] ONE_N = N'(1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N-1:0]     pending_q, pending_d;
  logic             overflow_q, overflow_d;
  logic             fire;
  logic [N-1:0]     clrMask;
  logic [IDX_W-1:0] selIdx;

  // Highest set bit wins; the loop never goes past N-1, so the result stays in range.
  function automatic logic [IDX_W-1:0] selectHigh(input logic [N-1:0] vec);
    logic [IDX_W-1:0] res;
    logic [IDX_W-1:0] pos;
    res = '0;
    for (int i = 0; i < N; i++) begin
      pos = IDX_W'(i);
      if (vec[pos]) res = pos;
    end
    return res;
  endfunction

`ifdef PENDING_PRIO_ENCODER_RR_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;

  // Search ptr, ptr-1, ..., 0, N-1, ..., ptr+1 and return the first set bit.
  function automatic logic [IDX_W-1:0] selectRr(input logic [N-1:0] vec,
                                                 input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] res;
    logic             found;
    int               pos;
    res   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      pos = int'(ptr) - i;
      if (pos < 0) pos = pos + N;
      if (!found && vec[pos[IDX_W-1:0]]) begin
        res   = pos[IDX_W-1:0];
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // Pointer moves just below the index that was accepted, wrapping 0 to N-1.
  always_comb begin
    ptr_d = ptr_q;
    if (fire) begin
      ptr_d = (idx_q == '0) ? IDX_W'(N - 1) : idx_q - IDX_W'(1);
    end
  end

  // Pointer register; starts at the top index so the first pick matches fixed priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= IDX_W'(N - 1);
    else        ptr_q <= ptr_d;
  end

  // The next offer already uses the post-fire pointer so consecutive picks rotate.
  always_comb begin
    selIdx = selectRr(pending_d, ptr_d);
  end
`else
  // Fixed priority: the highest pending index is always offered next.
  always_comb begin
    selIdx = selectHigh(pending_d);
  end
`endif

  // Handshake, clear mask, pending merge and overflow detection.
  always_comb begin
    fire       = (state_q == OFFER) && ready_i;
    clrMask    = fire ? (ONE_N << idx_q) : '0;
    pending_d  = (pending_q & ~clrMask) | req_i;
    overflow_d = |(req_i & pending_q & ~clrMask);
  end

  // Next-state and next-index logic; idx is only reloaded when a new offer starts.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (|pending_d) begin
          state_d = OFFER;
          idx_d   = selIdx;
        end
      end
      OFFER: begin
        if (fire) begin
          if (|pending_d) begin
            idx_d = selIdx;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; async reset drops any in-flight handshake immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign valid_o    = (state_q == OFFER);
  assign idx_o      = idx_q;
  assign pending_o  = pending_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_pending_prio_encoder.sv
// Self-checking bench for pending_prio_encoder (N=8): directed scenarios plus
// randomized traffic compared against a behavioural model of the pending set.
module tb_pending_prio_encoder;

  localparam int N     = 8;
  localparam int IDX_W = $clog2(N);

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     req_i;
  logic             ready_i;
  logic             valid_o;
  logic [IDX_W-1:0] idx_o;
  logic [N-1:0]     pending_o;
  logic             overflow_o;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  bit       mValid;
  int       mIdx;
  bit [7:0] mPending;
  bit       mOvf;
  int       mPtr;

  pending_prio_encoder #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req_i),
    .ready_i    (ready_i),
    .valid_o    (valid_o),
    .idx_o      (idx_o),
    .pending_o  (pending_o),
    .overflow_o (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Choose the index the encoder should offer for a given pending set.
  function automatic int pickIndex(input bit [7:0] vec, input int ptr);
`ifdef PENDING_PRIO_ENCODER_RR_EN
    for (int k = 0; k < N; k++) begin
      int pos;
      pos = (ptr - k + N) % N;
      if (vec[pos]) return pos;
    end
    return 0;
`else
    for (int k = N - 1; k >= 0; k--) begin
      if (vec[k]) return k;
    end
    return 0;
`endif
  endfunction

  task automatic modelReset();
    mValid   = 0;
    mIdx     = 0;
    mPending = '0;
    mOvf     = 0;
    mPtr     = N - 1;
  endtask

  // Advance the model by one clock with the given inputs.
  task automatic modelStep(input bit [7:0] req, input bit ready);
    bit       fire;
    bit [7:0] clr;
    bit [7:0] nxt;
    fire = mValid && ready;
    clr  = fire ? (8'd1 << mIdx) : 8'd0;
    nxt  = (mPending & ~clr) | req;
    mOvf = (req & mPending & ~clr) != 0;
    if (fire) mPtr = (mIdx == 0) ? N - 1 : mIdx - 1;
    if (!mValid || fire) begin
      if (nxt != 0) begin
        mValid = 1;
        mIdx   = pickIndex(nxt, mPtr);
      end else begin
        mValid = 0;
      end
    end
    mPending = nxt;
  endtask

  task automatic compareAll(input string tag);
    checkOutput({tag, ".valid"}, 32'(valid_o), 32'(mValid));
    checkOutput({tag, ".pending"}, 32'(pending_o), 32'(mPending));
    checkOutput({tag, ".overflow"}, 32'(overflow_o), 32'(mOvf));
    if (mValid) checkOutput({tag, ".idx"}, 32'(idx_o), 32'(mIdx));
  endtask

  // Called at a falling edge: check current outputs, drive inputs, wait one cycle.
  task automatic applyStimulus(input string tag, input bit [7:0] req, input bit ready);
    compareAll(tag);
    req_i   = req;
    ready_i = ready;
    modelStep(req, ready);
    @(negedge clk);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    @(negedge clk);
    modelReset();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    req_i   = '0;
    ready_i = 1'b0;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset.valid", 32'(valid_o), 32'd0);
    checkOutput("reset.idx", 32'(idx_o), 32'd0);
    checkOutput("reset.pending", 32'(pending_o), 32'd0);
    rst_n = 1'b1;

    // Reset mid-operation, asserted away from any clock edge.
    applyStimulus("t1a", 8'hFF, 1'b0);
    applyStimulus("t1b", 8'h00, 1'b0);
    applyStimulus("t1c", 8'h00, 1'b0);
    compareAll("t1d");
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset.valid", 32'(valid_o), 32'd0);
    checkOutput("midreset.idx", 32'(idx_o), 32'd0);
    checkOutput("midreset.pending", 32'(pending_o), 32'd0);
    checkOutput("midreset.overflow", 32'(overflow_o), 32'd0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("t1e", 8'h00, 1'b0);
    applyStimulus("t1f", 8'h00, 1'b1);

    // Single request.
    applyStimulus("t2a", 8'h01, 1'b1);
    checkOutput("single.valid", 32'(valid_o), 32'd1);
    checkOutput("single.idx", 32'(idx_o), 32'd0);
    applyStimulus("t2b", 8'h00, 1'b1);
    checkOutput("single.drained", 32'(valid_o), 32'd0);

    // Multi-hot drain 7, 3, 1.
    applyStimulus("t3a", 8'h8A, 1'b1);
    checkOutput("drain.first", 32'(idx_o), 32'd7);
    applyStimulus("t3b", 8'h00, 1'b1);
    checkOutput("drain.second", 32'(idx_o), 32'd3);
    applyStimulus("t3c", 8'h00, 1'b1);
    checkOutput("drain.third", 32'(idx_o), 32'd1);
    applyStimulus("t3d", 8'h00, 1'b1);
    checkOutput("drain.done", 32'(valid_o), 32'd0);
    checkOutput("drain.pending", 32'(pending_o), 32'd0);

    // Backpressure holds the offer stable.
    applyStimulus("t4a", 8'h14, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp.hold", 32'({valid_o, idx_o}), 32'({1'b1, 3'd4}));
      applyStimulus("t4h", 8'h00, 1'b0);
    end
    applyStimulus("t4b", 8'h00, 1'b1);
    checkOutput("bp.next", 32'(idx_o), 32'd2);
    applyStimulus("t4c", 8'h00, 1'b1);
    checkOutput("bp.done", 32'(valid_o), 32'd0);

    // Overflow on an already-pending bit, then re-request on fire.
    applyStimulus("t5a", 8'h14, 1'b0);
    applyStimulus("t5b", 8'h10, 1'b0);
    checkOutput("ovf.pulse", 32'(overflow_o), 32'd1);
    applyStimulus("t5c", 8'h00, 1'b0);
    checkOutput("ovf.oneshot", 32'(overflow_o), 32'd0);
    applyStimulus("t5d", 8'h00, 1'b1);
    checkOutput("ovf.once", 32'(idx_o), 32'd2);
    applyStimulus("t5e", 8'h00, 1'b1);
    applyStimulus("t5f", 8'h10, 1'b0);
    applyStimulus("t5g", 8'h10, 1'b1);
    checkOutput("rereq.ovf", 32'(overflow_o), 32'd0);
    checkOutput("rereq.offer", 32'({valid_o, idx_o}), 32'({1'b1, 3'd4}));
    applyStimulus("t5h", 8'h00, 1'b1);
    compareAll("t5i");

    // Priority mode with a continuously held request.
    doReset();
    for (int i = 0; i < 6; i++) begin
      int expIdx;
      applyStimulus("t6", 8'h82, 1'b1);
`ifdef PENDING_PRIO_ENCODER_RR_EN
      expIdx = (i % 2 == 0) ? 7 : 1;
`else
      expIdx = 7;
`endif
      checkOutput("prio.idx", 32'(idx_o), 32'(expIdx));
    end
    applyStimulus("t6z", 8'h00, 1'b1);

    // Randomized traffic with sparse requests and random backpressure.
    for (int i = 0; i < 400; i++) begin
      bit [7:0] r;
      r = 8'($urandom) & 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 3) == 0) r = '0;
      applyStimulus("rand", r, 1'($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 12; i++) applyStimulus("flush", 8'h00, 1'b1);
    compareAll("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
